can_bsp_unit: RTL and testbench

CAN bit stream processor sitting between the bit-timing logic and the frame-level MAC. It inserts stuff bits into the transmit stream at each `tx_point` and removes stuff bits from the receive stream at each `sample_point`. Stall flags tell the MAC when a bit slot was consumed by a stuff bit, so the MAC can hold or skip its data. It contains no bit-timing logic; both strobes come from the bit-timing block.

---
 rtl/can_bsp_if.sv | 49 ++++
 rtl/can_bsp_unit.sv | 120 ++++++++++++
 tb/tb_can_bsp_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/can_bsp_if.sv
// ---------------------------------------------------------------------------
// can_bsp_if
// Signal bundle between the bit-timing block / frame MAC and the CAN bit
// stream processor (can_bsp_unit).
//
// Build option: none here; see can_bsp_unit for CAN_BSP_STUFF_ERR_EN.
//
// Signals:
//   sample_point        one-clock strobe, RX sample instant
//   tx_point            one-clock strobe, TX bit-update instant
//   rx_in               bus level (1 = recessive)
//   tx_data_in          next TX data bit from the MAC
//   enable_tx_stuffing  enables TX stuff-bit insertion
//   enable_rx_stuffing  enables RX stuff-bit removal
//   tx_out              registered bit driven to the bus
//   rx_data_out         registered destuffed RX data bit
//   tx_stall            stuff bit currently on tx_out
//   rx_stall            last sampled RX bit was a stuff bit
//   stuff_err           one-clock pulse on a stuff rule violation
//
// Modports:
//   master  bit-timing / MAC side (drives strobes and data)
//   slave   bit stream processor side
// ---------------------------------------------------------------------------
interface can_bsp_if;
    logic sample_point;
    logic tx_point;
    logic rx_in;
    logic tx_data_in;
    logic enable_tx_stuffing;
    logic enable_rx_stuffing;
    logic tx_out;
    logic rx_data_out;
    logic tx_stall;
    logic rx_stall;
    logic stuff_err;

    modport master (
        output sample_point, tx_point, rx_in, tx_data_in,
               enable_tx_stuffing, enable_rx_stuffing,
        input  tx_out, rx_data_out, tx_stall, rx_stall, stuff_err
    );

    modport slave (
        input  sample_point, tx_point, rx_in, tx_data_in,
               enable_tx_stuffing, enable_rx_stuffing,
        output tx_out, rx_data_out, tx_stall, rx_stall, stuff_err
    );
endinterface

// File: rtl/can_bsp_unit.sv
// ---------------------------------------------------------------------------
// can_bsp_unit
// CAN bit stream processor. Inserts a complementary stuff bit into the TX
// stream after five equal bits and removes the stuff bit from the RX stream
// after five equal samples. TX and RX paths are independent and each only
// advances on its own strobe (tx_point / sample_point).
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous reset, active low
//   bus   can_bsp_if.slave (strobes, data, stall and error flags)
//
// Build option:
//   CAN_BSP_STUFF_ERR_EN  defined   -> a sixth equal RX bit at the stuff
//                                      position pulses stuff_err
//                         undefined -> stuff_err tied low, no compare logic
// ---------------------------------------------------------------------------
module can_bsp_unit (
    input  logic      clk,
    input  logic      rst,
    can_bsp_if.slave  bus
);
    localparam logic [2:0] RUN_MAX = 3'd5;

    logic       tx_out_q;
    logic       tx_stall_q;
    logic       tx_last;
    logic [2:0] tx_cnt;

    logic       rx_data_q;
    logic       rx_stall_q;
    logic       rx_last;
    logic [2:0] rx_cnt;

    // TX: a stuff bit counts as the first bit of the next run, so the
    // counter restarts at 1 with tx_last set to the stuff value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_out_q   <= 1'b1;
            tx_stall_q <= 1'b0;
            tx_last    <= 1'b1;
            tx_cnt     <= 3'd0;
        end else if (bus.tx_point) begin
            if (!bus.enable_tx_stuffing) begin
                tx_out_q   <= bus.tx_data_in;
                tx_stall_q <= 1'b0;
                tx_cnt     <= 3'd0;
                tx_last    <= bus.tx_data_in;
            end else if (tx_cnt == RUN_MAX) begin
                tx_out_q   <= ~tx_last;
                tx_stall_q <= 1'b1;
                tx_last    <= ~tx_last;
                tx_cnt     <= 3'd1;
            end else begin
                tx_out_q   <= bus.tx_data_in;
                tx_stall_q <= 1'b0;
                if (bus.tx_data_in == tx_last) begin
                    tx_cnt <= tx_cnt + 3'd1;
                end else begin
                    tx_cnt  <= 3'd1;
                    tx_last <= bus.tx_data_in;
                end
            end
        end
    end

    // RX: at the stuff position the sampled bit is dropped (rx_data_out
    // holds) but still seeds the next run, even if it violates the rule.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_q  <= 1'b1;
            rx_stall_q <= 1'b0;
            rx_last    <= 1'b1;
            rx_cnt     <= 3'd0;
        end else if (bus.sample_point) begin
            if (!bus.enable_rx_stuffing) begin
                rx_data_q  <= bus.rx_in;
                rx_stall_q <= 1'b0;
                rx_cnt     <= 3'd0;
                rx_last    <= bus.rx_in;
            end else if (rx_cnt == RUN_MAX) begin
                rx_stall_q <= 1'b1;
                rx_cnt     <= 3'd1;
                rx_last    <= bus.rx_in;
            end else begin
                rx_data_q  <= bus.rx_in;
                rx_stall_q <= 1'b0;
                if (bus.rx_in == rx_last) begin
                    rx_cnt <= rx_cnt + 3'd1;
                end else begin
                    rx_cnt  <= 3'd1;
                    rx_last <= bus.rx_in;
                end
            end
        end
    end

`ifdef CAN_BSP_STUFF_ERR_EN
    logic stuff_err_q;

    // Cleared every clock so the flag is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stuff_err_q <= 1'b0;
        end else begin
            stuff_err_q <= bus.sample_point && bus.enable_rx_stuffing &&
                           (rx_cnt == RUN_MAX) && (bus.rx_in == rx_last);
        end
    end

    assign bus.stuff_err = stuff_err_q;
`else
    assign bus.stuff_err = 1'b0;
`endif

    assign bus.tx_out      = tx_out_q;
    assign bus.tx_stall    = tx_stall_q;
    assign bus.rx_data_out = rx_data_q;
    assign bus.rx_stall    = rx_stall_q;
endmodule

// File: tb/tb_can_bsp_unit.sv
// ---------------------------------------------------------------------------
// tb_can_bsp_unit
// Directed and randomized stimulus for can_bsp_unit. The reference model
// keeps the recent wire/sample history of each path in a queue and decides
// stuff positions by looking for five equal trailing bits.
// ---------------------------------------------------------------------------
module tb_can_bsp_unit;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    can_bsp_if bus ();

    can_bsp_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    bit   tx_hist[$];
    bit   rx_hist[$];
    logic m_tx_out, m_tx_stall, m_rx_data, m_rx_stall, m_err;

    function automatic bit five_equal(input bit h[$]);
        int n;
        n = h.size();
        if (n < 5) return 1'b0;
        for (int i = 1; i < 5; i++)
            if (h[n-1-i] != h[n-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        tx_hist.delete();
        rx_hist.delete();
        m_tx_out   = 1'b1;
        m_tx_stall = 1'b0;
        m_rx_data  = 1'b1;
        m_rx_stall = 1'b0;
        m_err      = 1'b0;
    endtask

    task automatic model_step(input bit tp, input bit sp, input bit txd,
                              input bit rxi, input bit etx, input bit erx);
        bit s;
        m_err = 1'b0;
        if (tp) begin
            if (!etx) begin
                m_tx_out   = txd;
                m_tx_stall = 1'b0;
                tx_hist.delete();
            end else if (five_equal(tx_hist)) begin
                s = !tx_hist[tx_hist.size()-1];
                m_tx_out   = s;
                m_tx_stall = 1'b1;
                tx_hist.delete();
                tx_hist.push_back(s);
            end else begin
                m_tx_out   = txd;
                m_tx_stall = 1'b0;
                tx_hist.push_back(txd);
                if (tx_hist.size() > 5) void'(tx_hist.pop_front());
            end
        end
        if (sp) begin
            if (!erx) begin
                m_rx_data  = rxi;
                m_rx_stall = 1'b0;
                rx_hist.delete();
            end else if (five_equal(rx_hist)) begin
                m_rx_stall = 1'b1;
`ifdef CAN_BSP_STUFF_ERR_EN
                if (rxi == rx_hist[rx_hist.size()-1]) m_err = 1'b1;
`endif
                rx_hist.delete();
                rx_hist.push_back(rxi);
            end else begin
                m_rx_data  = rxi;
                m_rx_stall = 1'b0;
                rx_hist.push_back(rxi);
                if (rx_hist.size() > 5) void'(rx_hist.pop_front());
            end
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".tx_out"},      bus.tx_out,      m_tx_out);
        check({tag, ".tx_stall"},    bus.tx_stall,    m_tx_stall);
        check({tag, ".rx_data_out"}, bus.rx_data_out, m_rx_data);
        check({tag, ".rx_stall"},    bus.rx_stall,    m_rx_stall);
        check({tag, ".stuff_err"},   bus.stuff_err,   m_err);
    endtask

    // one clock: drive on falling edge, update model on rising edge,
    // compare 1 time unit later
    task automatic cycle(input string tag, input bit tp, input bit sp,
                         input bit txd, input bit rxi,
                         input bit etx, input bit erx);
        @(negedge clk);
        bus.tx_point           = tp;
        bus.sample_point       = sp;
        bus.tx_data_in         = txd;
        bus.rx_in              = rxi;
        bus.enable_tx_stuffing = etx;
        bus.enable_rx_stuffing = erx;
        @(posedge clk);
        model_step(tp, sp, txd, rxi, etx, erx);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.tx_point     = 1'b0;
        bus.sample_point = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit rx_seq1[8];
        bit rx_seq2[7];
        bit etx, erx, txd, rxi, tp, sp;

        rx_seq1 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        rx_seq2 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rst                    = 1'b0;
        bus.tx_point           = 1'b0;
        bus.sample_point       = 1'b0;
        bus.tx_data_in         = 1'b0;
        bus.rx_in              = 1'b1;
        bus.enable_tx_stuffing = 1'b0;
        bus.enable_rx_stuffing = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.tx_out",      bus.tx_out,      1'b1);
        check("reset.rx_data_out", bus.rx_data_out, 1'b1);
        check("reset.tx_stall",    bus.tx_stall,    1'b0);
        check("reset.rx_stall",    bus.rx_stall,    1'b0);
        check("reset.stuff_err",   bus.stuff_err,   1'b0);
        @(negedge clk);
        rst = 1'b1;
        cycle("idle", 0, 0, 0, 1, 1, 1);

        // TX stuffing: six zeros, the sixth slot carries the stuff bit
        for (int i = 1; i <= 5; i++) begin
            cycle("tx_run", 1, 0, 0, 1, 1, 1);
            check("tx_run.literal", bus.tx_out, 1'b0);
        end
        cycle("tx_slot6", 1, 0, 0, 1, 1, 1);
        check("tx_slot6.out",   bus.tx_out,   1'b1);
        check("tx_slot6.stall", bus.tx_stall, 1'b1);
        cycle("tx_hold", 0, 0, 0, 1, 1, 1);
        check("tx_hold.stall", bus.tx_stall, 1'b1);
        cycle("tx_slot7", 1, 0, 0, 1, 1, 1);
        check("tx_slot7.out",   bus.tx_out,   1'b0);
        check("tx_slot7.stall", bus.tx_stall, 1'b0);

        // TX stuffing disabled: no stuff bits
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle("tx_nostuff", 1, 0, 0, 1, 0, 1);
            check("tx_nostuff.out",   bus.tx_out,   1'b0);
            check("tx_nostuff.stall", bus.tx_stall, 1'b0);
        end

        // RX destuffing, legal stuff bit
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle("rx_seq1", 0, 1, 0, rx_seq1[i], 1, 1);
            if (i < 6) check("rx_seq1.follow", bus.rx_data_out, rx_seq1[i]);
        end

        do_reset();
        for (int i = 0; i < 6; i++) cycle("rx_seq1b", 0, 1, 0, rx_seq1[i], 1, 1);
        cycle("rx_seq1.s7", 0, 1, 0, rx_seq1[6], 1, 1);
        check("rx_s7.stall", bus.rx_stall,    1'b1);
        check("rx_s7.data",  bus.rx_data_out, 1'b1);
        cycle("rx_seq1.s8", 0, 1, 0, rx_seq1[7], 1, 1);
        check("rx_s8.stall", bus.rx_stall,    1'b0);
        check("rx_s8.data",  bus.rx_data_out, 1'b1);

        // RX stuff violation
        do_reset();
        for (int i = 0; i < 7; i++) cycle("rx_seq2", 0, 1, 0, rx_seq2[i], 1, 1);
        check("rx_err.stall", bus.rx_stall, 1'b1);
`ifdef CAN_BSP_STUFF_ERR_EN
        check("rx_err.pulse", bus.stuff_err, 1'b1);
`else
        check("rx_err.pulse", bus.stuff_err, 1'b0);
`endif
        cycle("rx_err_after", 0, 0, 0, 1, 1, 1);
        check("rx_err.one_clk", bus.stuff_err, 1'b0);

        // both paths reach the stuff position on the same clock
        do_reset();
        for (int i = 0; i < 5; i++) cycle("both_run", 1, 1, 0, 0, 1, 1);
        cycle("both_stuff", 1, 1, 0, 1, 1, 1);
        check("both.tx_stall", bus.tx_stall, 1'b1);
        check("both.rx_stall", bus.rx_stall, 1'b1);
        check("both.tx_out",   bus.tx_out,   1'b1);
        check("both.rx_data",  bus.rx_data_out, 1'b0);

        // asynchronous reset while both stalls are high
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clk);
        rst = 1'b1;

        // randomized: biased toward long runs so stuffing happens often
        txd = 1'b0;
        rxi = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            tp  = ($urandom_range(0, 2) != 0);
            sp  = ($urandom_range(0, 2) != 0);
            etx = ($urandom_range(0, 19) != 0);
            erx = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 4) == 0) txd = ~txd;
            if ($urandom_range(0, 4) == 0) rxi = ~rxi;
            cycle("random", tp, sp, txd, rxi, etx, erx);
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
